// File: rtl/ibex_instr_bus_responder_if.sv
// Instruction-fetch bus between an initiator (master) and the responder (slave).
interface ibex_instr_bus_responder_if;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o
  );

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o
  );
endinterface

// File: rtl/ibex_instr_bus_responder.sv
// In-order instruction-bus responder: queues granted fetches, applies a per-request
// delay, reads backing memory or flags an error-region hit, and returns responses in order.
module ibex_instr_bus_responder #(
  parameter int unsigned NumReqs = 2,
  parameter int unsigned MemAw   = 10,
  parameter logic [31:0] ErrBase = 32'hFFFF_0000,
  parameter logic [31:0] ErrMask = 32'hFFFF_0000
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  ibex_instr_bus_responder_if.slave     bus,
  output logic                          mem_req_o,
  output logic [MemAw-1:0]              mem_addr_o,
  input  logic [31:0]                   mem_rdata_i,
  input  logic                          stall_i,
  input  logic [3:0]                    delay_i,
  output logic [2:0]                    outstanding_o
);

  localparam int unsigned PtrW = (NumReqs > 1) ? $clog2(NumReqs) : 1;

  typedef struct packed {
    logic [MemAw-1:0] addr;
    logic             err;
    logic [3:0]       cnt;
  } entry_t;

  typedef enum logic [1:0] {IDLE, COUNT, ISSUE, RESP} state_e;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(NumReqs - 1)) ? '0 : p + PtrW'(1);
  endfunction

  entry_t          r_q [NumReqs];
  logic [PtrW-1:0] r_rd, r_wr;
  logic [2:0]      r_count;
  logic [3:0]      r_cnt;
  state_e          r_state;

  state_e          w_state_nxt;
  logic [3:0]      w_cnt_nxt;
  logic            w_gnt, w_pop, w_have_nh, w_resp;
  entry_t          w_push, w_head, w_nh;

  assign w_gnt  = bus.instr_req_i & ~stall_i & ~rst_i & (r_count < 3'(NumReqs));
  assign w_pop  = (r_state == RESP);
  assign w_head = r_q[r_rd];

  always_comb begin
    w_push.addr = bus.instr_addr_i[MemAw+1:2];
    w_push.err  = ((bus.instr_addr_i & ErrMask) == ErrBase);
    w_push.cnt  = delay_i;
  end

  // Next-state: choose the entry that becomes head (a same-cycle push counts as present).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_have_nh   = 1'b0;
    w_nh        = '0;
    case (r_state)
      IDLE: begin
        if (r_count != 3'd0) begin
          w_have_nh = 1'b1;
          w_nh      = w_head;
        end else if (w_gnt) begin
          w_have_nh = 1'b1;
          w_nh      = w_push;
        end
      end
      COUNT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) w_state_nxt = ISSUE;
      end
      ISSUE: w_state_nxt = RESP;
      RESP: begin
        w_state_nxt = IDLE;
        if (r_count >= 3'd2) begin
          w_have_nh = 1'b1;
          w_nh      = r_q[ptr_inc(r_rd)];
        end else if (w_gnt) begin
          w_have_nh = 1'b1;
          w_nh      = w_push;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_have_nh) begin
      if (w_nh.cnt != 4'd0) begin
        w_state_nxt = COUNT;
        w_cnt_nxt   = w_nh.cnt;
      end else begin
        w_state_nxt = ISSUE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_gnt) r_wr <= ptr_inc(r_wr);
      if (w_pop) r_rd <= ptr_inc(r_rd);
      case ({w_gnt, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage needs no reset: occupancy is tracked by r_count.
  always_ff @(posedge clk_i) begin
    if (w_gnt) r_q[r_wr] <= w_push;
  end

  assign w_resp             = (r_state == RESP) & ~rst_i;
  assign bus.instr_gnt_o    = w_gnt;
  assign bus.instr_rvalid_o = w_resp;
  assign bus.instr_err_o    = w_resp & w_head.err;
  assign bus.instr_rdata_o  = (w_resp & ~w_head.err) ? mem_rdata_i : 32'd0;
  assign mem_req_o          = (r_state == ISSUE) & ~w_head.err & ~rst_i;
  assign mem_addr_o         = mem_req_o ? w_head.addr : '0;
  assign outstanding_o      = r_count;

endmodule

// File: tb/tb_ibex_instr_bus_responder.sv
// Bench for ibex_instr_bus_responder: directed vector table, corner sequences and
// random traffic checked against a timestamp-based response model.
module tb_ibex_instr_bus_responder;
  localparam int NREQ = 2;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        mem_req_o;
  logic [9:0]  mem_addr_o;
  logic [31:0] mem_rdata_i;
  logic        stall_i;
  logic [3:0]  delay_i;
  logic [2:0]  outstanding_o;

  ibex_instr_bus_responder_if bus();

  ibex_instr_bus_responder #(.NumReqs(NREQ), .MemAw(10)) dut (
    .clk_i(clk), .rst_i(rst_i), .bus(bus),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
    .stall_i(stall_i), .delay_i(delay_i), .outstanding_o(outstanding_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] wa;
    logic       err;
    int         resp;
  } pend_t;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic [3:0]  d;
    logic        rst;
    logic        gnt;
    logic [2:0]  outs;
    logic        rv;
    logic [31:0] rdata;
    logic        err;
    logic        mreq;
    logic [9:0]  maddr;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_resp = -10;
  pend_t       q[$];
  logic [31:0] mem_model [1024];
  logic        prev_mreq = 1'b0;
  logic [9:0]  prev_maddr = '0;

  logic        s_gnt, s_rv, s_err, s_mreq;
  logic [31:0] s_rdata;
  logic [2:0]  s_out;
  logic [9:0]  s_maddr;

  vec_t vt [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t mv(logic req, logic [31:0] addr, logic [3:0] d, logic rst,
                              logic gnt, logic [2:0] outs, logic rv, logic [31:0] rdata,
                              logic err, logic mreq, logic [9:0] maddr);
    vec_t v;
    v.req = req; v.addr = addr; v.d = d; v.rst = rst; v.gnt = gnt; v.outs = outs;
    v.rv = rv; v.rdata = rdata; v.err = err; v.mreq = mreq; v.maddr = maddr;
    return v;
  endfunction

  // One clock cycle: drive at negedge, sample 1ns later, check against the model.
  task automatic cycle(input logic req, input logic [31:0] addr, input logic stall,
                       input logic [3:0] d, input logic rst);
    logic        e_gnt, e_rv, e_err, e_mreq;
    logic [31:0] e_rdata;
    logic [9:0]  e_maddr;
    logic [2:0]  e_out;
    pend_t       p;
    int          s;
    bus.instr_req_i  = req;
    bus.instr_addr_i = addr;
    stall_i          = stall;
    delay_i          = d;
    rst_i            = rst;
    mem_rdata_i      = prev_mreq ? mem_model[prev_maddr] : $urandom;
    #1;
    e_out   = 3'(q.size());
    e_gnt   = req && !stall && !rst && (q.size() < NREQ);
    e_rv    = !rst && q.size() > 0 && q[0].resp == cyc;
    e_err   = e_rv && q[0].err;
    e_rdata = (e_rv && !q[0].err) ? mem_model[q[0].wa] : 32'd0;
    e_mreq  = !rst && q.size() > 0 && q[0].resp == cyc + 1 && !q[0].err;
    e_maddr = e_mreq ? q[0].wa : 10'd0;
    s_gnt = bus.instr_gnt_o; s_rv = bus.instr_rvalid_o; s_err = bus.instr_err_o;
    s_rdata = bus.instr_rdata_o; s_out = outstanding_o; s_mreq = mem_req_o; s_maddr = mem_addr_o;
    chk("gnt", 32'(s_gnt), 32'(e_gnt));
    chk("outstanding", 32'(s_out), 32'(e_out));
    chk("rvalid", 32'(s_rv), 32'(e_rv));
    chk("err", 32'(s_err), 32'(e_err));
    chk("rdata", s_rdata, e_rdata);
    chk("mem_req", 32'(s_mreq), 32'(e_mreq));
    chk("mem_addr", 32'(s_maddr), 32'(e_maddr));
    prev_mreq  = s_mreq;
    prev_maddr = s_maddr;
    if (rst) begin
      q.delete();
      last_resp = -10;
    end else begin
      if (q.size() > 0 && q[0].resp == cyc) void'(q.pop_front());
      if (e_gnt) begin
        p.wa  = addr[11:2];
        p.err = ((addr & 32'hFFFF_0000) == 32'hFFFF_0000);
        s     = (cyc + 1 > last_resp + 1) ? cyc + 1 : last_resp + 1;
        p.resp = s + int'(d) + 1;
        last_resp = p.resp;
        q.push_back(p);
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 60) begin
      cycle(1'b0, 32'd0, 1'b0, 4'd0, 1'b0);
      n++;
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    logic [5:0]  gpat;
    int          rvcnt;
    logic [31:0] ra;
    logic [3:0]  rd;

    for (int i = 0; i < 1024; i++) mem_model[i] = $urandom;
    mem_model[4] = 32'hDEAD_BEEF;
    mem_model[8] = 32'h1111_2222;
    mem_model[9] = 32'h3333_4444;

    vt[0]  = mv(1, 32'h10, 0, 1,  0, 0, 0, 32'h0, 0, 0, 10'd0);
    vt[1]  = mv(1, 32'h10, 0, 0,  1, 0, 0, 32'h0, 0, 0, 10'd0);
    vt[2]  = mv(0, 32'h0,  0, 0,  0, 1, 0, 32'h0, 0, 1, 10'd4);
    vt[3]  = mv(0, 32'h0,  0, 0,  0, 1, 1, 32'hDEAD_BEEF, 0, 0, 10'd0);
    vt[4]  = mv(1, 32'hFFFF_0004, 0, 0, 1, 0, 0, 32'h0, 0, 0, 10'd0);
    vt[5]  = mv(0, 32'h0,  0, 0,  0, 1, 0, 32'h0, 0, 0, 10'd0);
    vt[6]  = mv(0, 32'h0,  0, 0,  0, 1, 1, 32'h0, 1, 0, 10'd0);
    vt[7]  = mv(1, 32'h20, 3, 0,  1, 0, 0, 32'h0, 0, 0, 10'd0);
    vt[8]  = mv(1, 32'h24, 0, 0,  1, 1, 0, 32'h0, 0, 0, 10'd0);
    vt[9]  = mv(0, 32'h40, 15, 0, 0, 2, 0, 32'h0, 0, 0, 10'd0);
    vt[10] = mv(0, 32'h44, 15, 0, 0, 2, 0, 32'h0, 0, 0, 10'd0);
    vt[11] = mv(0, 32'h0,  0, 0,  0, 2, 0, 32'h0, 0, 1, 10'd8);
    vt[12] = mv(0, 32'h0,  0, 0,  0, 2, 1, 32'h1111_2222, 0, 0, 10'd0);
    vt[13] = mv(0, 32'h0,  0, 0,  0, 1, 0, 32'h0, 0, 1, 10'd9);
    vt[14] = mv(0, 32'h0,  0, 0,  0, 1, 1, 32'h3333_4444, 0, 0, 10'd0);
    vt[15] = mv(0, 32'h0,  0, 0,  0, 0, 0, 32'h0, 0, 0, 10'd0);

    bus.instr_req_i = 1'b0; bus.instr_addr_i = '0; stall_i = 1'b0; delay_i = '0;
    mem_rdata_i = '0; rst_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Directed table: single read, error region, delay and ordering.
    for (int i = 0; i < 16; i++) begin
      cycle(vt[i].req, vt[i].addr, 1'b0, vt[i].d, vt[i].rst);
      chk($sformatf("tbl%0d_gnt", i), 32'(s_gnt), 32'(vt[i].gnt));
      chk($sformatf("tbl%0d_out", i), 32'(s_out), 32'(vt[i].outs));
      chk($sformatf("tbl%0d_rv", i), 32'(s_rv), 32'(vt[i].rv));
      chk($sformatf("tbl%0d_rdata", i), s_rdata, vt[i].rdata);
      chk($sformatf("tbl%0d_err", i), 32'(s_err), 32'(vt[i].err));
      chk($sformatf("tbl%0d_mreq", i), 32'(s_mreq), 32'(vt[i].mreq));
      chk($sformatf("tbl%0d_maddr", i), 32'(s_maddr), 32'(vt[i].maddr));
    end

    // Full queue: held request grants twice, then only after each pop.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 32'h100 + 32'(i * 4), 1'b0, 4'd0, 1'b0);
      gpat[5 - i] = s_gnt;
    end
    chk("full_gnt_pattern", 32'(gpat), 32'(6'b110101));
    drain();

    // Stall: no grants while stalled; grant in the cycle stall drops.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 32'h200, 1'b1, 4'd0, 1'b0);
      chk("stall_nogrant", 32'(s_gnt), 32'd0);
    end
    cycle(1'b1, 32'h200, 1'b0, 4'd0, 1'b0);
    chk("stall_release_gnt", 32'(s_gnt), 32'd1);
    drain();

    // Reset mid-flight drops both pending responses.
    cycle(1'b1, 32'h300, 1'b0, 4'd5, 1'b0);
    cycle(1'b1, 32'h304, 1'b0, 4'd5, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 4'd0, 1'b1);
    chk("rst_out_before", 32'(s_out), 32'd2);
    rvcnt = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 32'h0, 1'b0, 4'd0, 1'b0);
      if (i == 0) chk("rst_out_after", 32'(s_out), 32'd0);
      rvcnt += int'(s_rv);
    end
    chk("rst_no_rvalid", 32'(rvcnt), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      ra = ($urandom_range(0, 4) == 0) ? (32'hFFFF_0000 | ($urandom & 32'hFFFF)) : $urandom;
      rd = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(3, 15)) : 4'($urandom_range(0, 2));
      cycle(1'($urandom_range(0, 9) < 7), ra, 1'($urandom_range(0, 4) == 0), rd,
            1'($urandom_range(0, 99) == 0));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ibex_instr_bus_responder.md
IBEX_INSTR_BUS_RESPONDER -- requirements
Module: ibex_instr_bus_responder

Interface
REQ-001 The block SHALL have parameter NumReqs, default 2, meaning the maximum number of outstanding granted requests (range 1-4).
REQ-002 The block SHALL have parameter MemAw, default 10, meaning the backing-memory word-address width.
REQ-003 The block SHALL have parameter ErrBase, default 32'hFFFF_0000, meaning the base of the error region.
REQ-004 The block SHALL have parameter ErrMask, default 32'hFFFF_0000; an address is in the error region when (addr & ErrMask) == ErrBase.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk_i  input  1  clock; all state updates on the rising edge.
REQ-007 rst_i  input  1  synchronous active-high reset.
REQ-008 instr_req_i  input  1  fetch request from the instruction-side initiator.
REQ-009 instr_addr_i  input  32  request byte address; bits [1:0] ignored.
REQ-010 instr_gnt_o  output  1  request accepted this cycle (combinational).
REQ-011 instr_rvalid_o  output  1  response valid (registered).
REQ-012 instr_rdata_o  output  32  response data.
REQ-013 instr_err_o  output  1  response error flag, qualified by instr_rvalid_o.
REQ-014 mem_req_o  output  1  backing-memory read strobe.
REQ-015 mem_addr_o  output  MemAw  backing-memory word address.
REQ-016 mem_rdata_i  input  32  backing-memory data, valid the cycle after mem_req_o.
REQ-017 stall_i  input  1  suppresses grants while high.
REQ-018 delay_i  input  4  extra response delay in cycles, sampled at grant.
REQ-019 outstanding_o  output  3  number of granted requests not yet responded to.

Function
REQ-020 instr_gnt_o SHALL equal instr_req_i & !stall_i & (outstanding < NumReqs); a full queue SHALL NOT grant, even when a response pops in the same cycle.
REQ-021 On grant the block SHALL push an in-order queue entry holding {instr_addr_i[MemAw+1:2], err = error-region match, cnt = delay_i}.
REQ-022 Changes on delay_i or instr_addr_i after the grant cycle SHALL NOT affect a queued entry.
REQ-023 The head entry SHALL be serviced by an FSM with states IDLE, COUNT, ISSUE and RESP; only the head entry counts down.
REQ-024 IDLE: when the queue is non-empty, the FSM SHALL go to COUNT if head cnt > 0, else to ISSUE.
REQ-025 COUNT: the FSM SHALL decrement head cnt each cycle and go to ISSUE in the cycle after cnt reaches 1 -> 0.
REQ-026 ISSUE: the block SHALL assert mem_req_o=1 with mem_addr_o=head address when head err=0; when err=1, mem_req_o SHALL stay 0. The FSM SHALL then go to RESP.
REQ-027 RESP: the block SHALL assert instr_rvalid_o=1 for exactly one cycle and pop the head.
  - err=0: instr_rdata_o=mem_rdata_i, instr_err_o=0.
  - err=1: instr_rdata_o=0, instr_err_o=1.
REQ-028 After RESP the FSM SHALL go to COUNT or ISSUE per the next head, or to IDLE if the queue is empty. An entry pushed in the same cycle counts as present.
REQ-029 Latency SHALL be: grant at cycle T with empty queue and delay d -> rvalid at T+2+d. Steady-state throughput is one response per 2 cycles at d=0.
REQ-030 Responses SHALL be returned strictly in grant order.
REQ-031 outstanding_o SHALL increment on grant, decrement on the RESP pop, and stay unchanged when both occur in the same cycle.
REQ-032 When instr_rvalid_o=0, instr_rdata_o and instr_err_o SHALL be 0.
REQ-033 mem_addr_o SHALL be 0 when mem_req_o=0.

Reset
REQ-034 While rst_i=1 at a clock edge, the block SHALL empty the queue, set the FSM to IDLE, set outstanding_o=0 and instr_rvalid_o=0.
REQ-035 While rst_i=1, instr_gnt_o, mem_req_o, mem_addr_o, instr_rdata_o and instr_err_o SHALL be 0.
REQ-036 A reset asserted mid-transaction SHALL drop all pending responses; no rvalid SHALL be produced for requests granted before reset.

Verification
REQ-037 Single read: addr 0x0000_0010, d=0, memory returns 0xDEAD_BEEF -> gnt at T, mem_req_o at T+1 with mem_addr_o=4, rvalid at T+2 with rdata 0xDEAD_BEEF, err=0.
REQ-038 Error region: addr 0xFFFF_0004 -> mem_req_o never asserted, rvalid at T+2 with err=1 and rdata=0.
REQ-039 Delay and ordering: grant A (d=3), then B (d=0) -> A rvalid at T+5, B rvalid at T+7, outstanding_o sequence 1,2,...,1,0.
REQ-040 Full queue: hold req with NumReqs=2 -> exactly 2 grants, gnt=0 while outstanding_o=2, and gnt reasserts the cycle after a pop.
REQ-041 Stall: stall_i=1 with req=1 for 5 cycles -> no grants and outstanding_o=0; the first grant occurs in the cycle stall_i drops.
REQ-042 Reset mid-flight: 2 outstanding, rst_i pulsed for 1 cycle -> outstanding_o=0, FSM IDLE, and no rvalid within 10 following cycles without new requests.
